phantom_clock: RTL and testbench

PHANTOM_CLOCK -- requirements
Module: phantom_clock

---
 rtl/coco_rtc_pkg.sv | 19 +
 rtl/bin2bcd99.sv | 15 +
 rtl/phantom_clock.sv | 104 ++++++++++
 tb/tb_phantom_clock.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/coco_rtc_pkg.sv
// Shared types and constants for the phantom clock.
// Covers the FSM states, the default recognition pattern and the frame byte layout.
package coco_rtc_pkg;
  typedef enum logic {HUNT = 1'b0, XFER = 1'b1} state_e;

  localparam logic [63:0] PATTERN_DEFAULT = 64'h5CA33AC55CA33AC5;

  localparam int BY_HSEC = 0;
  localparam int BY_SEC  = 1;
  localparam int BY_MIN  = 2;
  localparam int BY_HOUR = 3;
  localparam int BY_DWK  = 4;
  localparam int BY_DATE = 5;
  localparam int BY_MNTH = 6;
  localparam int BY_YEAR = 7;

  // Fields that need a BCD converter: sec, min, hour, date, month, year.
  localparam int NUM_BCD = 6;
endpackage

// File: rtl/bin2bcd99.sv
// Combinational 7-bit binary to two-digit BCD converter.
// Values above 99 keep only the low four bits of the tens digit.
module bin2bcd99 (
  input  logic [6:0] bin_i,
  output logic [7:0] bcd_o
);
  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens  = 4'(bin_i / 7'd10);
    ones  = 4'(bin_i - 7'(tens) * 7'd10);
    bcd_o = {tens, ones};
  end
endmodule

// File: rtl/phantom_clock.sv
// Serial-unlock real-time clock: hunts a 64-bit write pattern, then streams
// a frozen 64-bit BCD time frame one bit per access.
module phantom_clock
  import coco_rtc_pkg::*;
#(
  parameter logic [63:0] PATTERN = PATTERN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       acc,
  input  logic       a2,
  input  logic       a0,
  input  logic [6:0] i_year,
  input  logic [3:0] i_mnth,
  input  logic [4:0] i_dmth,
  input  logic [2:0] i_dwk,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  output logic       dout,
  output logic       drive,
  output logic       active
);
  state_e      state_q, state_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  bc_q, bc_d;
  logic [63:0] frame_q, frame_d;
  logic [63:0] snap;

  logic [NUM_BCD-1:0][6:0] bin;
  logic [NUM_BCD-1:0][7:0] bcd;

  assign bin = {i_year, {3'b0, i_mnth}, {2'b0, i_dmth},
                {2'b0, i_hour}, {1'b0, i_min}, {1'b0, i_sec}};

  for (genvar g = 0; g < NUM_BCD; g++) begin : g_cvt
    bin2bcd99 u_cvt (.bin_i(bin[g]), .bcd_o(bcd[g]));
  end

  always_comb begin
    snap                  = '0;
    snap[8*BY_HSEC +: 8]  = 8'h00;
    snap[8*BY_SEC  +: 8]  = bcd[0];
    snap[8*BY_MIN  +: 8]  = bcd[1];
    snap[8*BY_HOUR +: 8]  = {1'b0, bcd[2][6:0]};
    snap[8*BY_DWK  +: 8]  = {5'b0, i_dwk};
    snap[8*BY_DATE +: 8]  = bcd[3];
    snap[8*BY_MNTH +: 8]  = bcd[4];
    snap[8*BY_YEAR +: 8]  = bcd[5];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      ptr_q   <= '0;
      bc_q    <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bc_q    <= bc_d;
      frame_q <= frame_d;
    end
  end

  // The frame is only loaded on the unlocking write, so it stays frozen for the transfer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bc_d    = bc_q;
    frame_d = frame_q;
    active  = (state_q == XFER);
    drive   = 1'b0;
    dout    = 1'b0;
    case (state_q)
      HUNT: begin
        if (acc) begin
          if (!a2 && (a0 == PATTERN[ptr_q])) begin
            ptr_d = ptr_q + 6'd1;
            if (ptr_q == 6'd63) begin
              state_d = XFER;
              bc_d    = '0;
              frame_d = snap;
            end
          end else begin
            ptr_d = '0;
          end
        end
      end
      XFER: begin
        dout  = frame_q[bc_q];
        drive = acc & a2;
        if (acc) begin
          bc_d = bc_q + 6'd1;
          if (bc_q == 6'd63) begin
            state_d = HUNT;
            ptr_d   = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end
endmodule

// File: tb/tb_phantom_clock.sv
// Self-checking bench for phantom_clock: table vectors, corner sequences and
// a randomized run checked against a behavioural model of the unlock/transfer rules.
module tb_phantom_clock;
  localparam logic [63:0] PAT = 64'h5CA33AC55CA33AC5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       acc = 1'b0, a2 = 1'b0, a0 = 1'b0;
  logic [6:0] i_year = '0;
  logic [3:0] i_mnth = '0;
  logic [4:0] i_dmth = '0;
  logic [2:0] i_dwk = '0;
  logic [4:0] i_hour = '0;
  logic [5:0] i_min = '0, i_sec = '0;
  logic       dout, drive, active;

  phantom_clock #(.PATTERN(PAT)) dut (
    .clk(clk), .reset(reset), .acc(acc), .a2(a2), .a0(a0),
    .i_year(i_year), .i_mnth(i_mnth), .i_dmth(i_dmth), .i_dwk(i_dwk),
    .i_hour(i_hour), .i_min(i_min), .i_sec(i_sec),
    .dout(dout), .drive(drive), .active(active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_xfer;
  int          m_ptr, m_bc;
  logic [63:0] m_frame;
  logic        last_dout, last_drive;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = 8'(((v / 10) % 16) * 16 + (v % 10));
  endfunction

  function automatic logic [63:0] model_frame();
    model_frame = {to_bcd(int'(i_year)), to_bcd(int'(i_mnth)), to_bcd(int'(i_dmth)),
                   {5'b0, i_dwk}, to_bcd(int'(i_hour)), to_bcd(int'(i_min)),
                   to_bcd(int'(i_sec)), 8'h00};
  endfunction

  // One access cycle; called at posedge+1, returns at the next posedge+1.
  task automatic access(input bit rd, input bit d);
    logic exp_dout, exp_drive, exp_act;
    exp_act   = m_xfer;
    exp_drive = m_xfer & rd;
    exp_dout  = m_xfer ? m_frame[m_bc] : 1'b0;
    acc = 1'b1; a2 = rd; a0 = d;
    @(negedge clk);
    last_dout  = dout;
    last_drive = drive;
    chk("dout", {63'b0, dout}, {63'b0, exp_dout});
    chk("drive", {63'b0, drive}, {63'b0, exp_drive});
    chk("active", {63'b0, active}, {63'b0, exp_act});
    if (m_xfer) begin
      if (m_bc == 63) begin m_xfer = 0; m_ptr = 0; end
      m_bc = (m_bc + 1) % 64;
    end else if (rd) begin
      m_ptr = 0;
    end else if (d == PAT[m_ptr]) begin
      if (m_ptr == 63) begin
        m_xfer = 1; m_bc = 0; m_frame = model_frame(); m_ptr = 0;
      end else m_ptr++;
    end else begin
      m_ptr = 0;
    end
    @(posedge clk); #1;
    acc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_active", {63'b0, active}, 64'd0);
    chk("rst_drive", {63'b0, drive}, 64'd0);
    chk("rst_dout", {63'b0, dout}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_xfer = 0; m_ptr = 0; m_bc = 0; m_frame = '0;
  endtask

  task automatic send_pattern(input int flip);
    for (int i = 0; i < 64; i++) access(1'b0, (i == flip) ? ~PAT[i] : PAT[i]);
  endtask

  task automatic read_frame(output logic [63:0] w, output bit any_drive);
    any_drive = 0;
    for (int i = 0; i < 64; i++) begin
      access(1'b1, 1'b0);
      w[i] = last_dout;
      if (last_drive) any_drive = 1;
    end
  endtask

  typedef struct {
    logic [6:0]  yr; logic [3:0] mo; logic [4:0] dm; logic [2:0] dw;
    logic [4:0]  hr; logic [5:0] mi; logic [5:0] se;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    bit          anyd;
    int          n;

    vecs[0] = '{7'd24, 4'd2, 5'd29, 3'd4, 5'd23, 6'd59, 6'd58, 64'h24022904_23595800};
    vecs[1] = '{7'd99, 4'd12, 5'd31, 3'd7, 5'd0, 6'd0, 6'd0, 64'h99123107_00000000};
    vecs[2] = '{7'd0, 4'd1, 5'd1, 3'd1, 5'd9, 6'd10, 6'd59, 64'h00010101_09105900};
    vecs[3] = '{7'd127, 4'd15, 5'd31, 3'd0, 5'd31, 6'd63, 6'd63, 64'hC7153100_31636300};
    vecs[4] = '{7'd100, 4'd10, 5'd19, 3'd3, 5'd20, 6'd45, 6'd30, 64'hA0101903_20453000};

    #1;
    do_reset();

    // Table: unlock, read whole frame, compare with hand-computed BCD bytes.
    foreach (vecs[k]) begin
      {i_year, i_mnth, i_dmth, i_dwk} = {vecs[k].yr, vecs[k].mo, vecs[k].dm, vecs[k].dw};
      {i_hour, i_min, i_sec} = {vecs[k].hr, vecs[k].mi, vecs[k].se};
      send_pattern(-1);
      read_frame(w, anyd);
      chk("vec_frame", w, vecs[k].exp);
      chk("vec_done", {63'b0, active}, 64'd0);
      idle(2);
    end

    // Corrupted bit 17: never unlocks.
    send_pattern(17);
    read_frame(w, anyd);
    chk("bad_pat_drive", {63'b0, anyd}, 64'd0);
    chk("bad_pat_active", {63'b0, active}, 64'd0);

    // Partial pattern broken by a read, then a full pattern.
    for (int i = 0; i < 40; i++) access(1'b0, PAT[i]);
    access(1'b1, 1'b0);
    chk("partial_active", {63'b0, active}, 64'd0);
    for (int i = 0; i < 63; i++) access(1'b0, PAT[i]);
    chk("pre_match", {63'b0, active}, 64'd0);
    access(1'b0, PAT[63]);
    chk("post_match", {63'b0, active}, 64'd1);

    // Frame frozen while seconds tick mid-transfer (this transfer is from the match above).
    // Drain it, then re-unlock with i_sec=10.
    read_frame(w, anyd);
    i_sec = 6'd10;
    send_pattern(-1);
    for (int i = 0; i < 8; i++) begin access(1'b1, 1'b0); w[i] = last_dout; end
    i_sec = 6'd11;
    for (int i = 8; i < 64; i++) begin access(1'b1, 1'b0); w[i] = last_dout; end
    chk("frozen_sec", {56'b0, w[15:8]}, 64'h10);

    // Asynchronous reset mid-transfer, then an access right after release.
    send_pattern(-1);
    for (int i = 0; i < 20; i++) access(1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("abort_active", {63'b0, active}, 64'd0);
    chk("abort_drive", {63'b0, drive}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_xfer = 0; m_ptr = 0; m_bc = 0; m_frame = '0;
    read_frame(w, anyd);
    chk("abort_reads", {63'b0, anyd}, 64'd0);

    // Mixed reads/writes with idle gaps: writes advance bc too.
    send_pattern(-1);
    for (int i = 0; i < 64; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i == 62) chk("mixed_63", {63'b0, active}, 64'd1);
      idle($urandom_range(0, 2));
    end
    chk("mixed_end", {63'b0, active}, 64'd0);

    // Randomized run against the model.
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_year = 7'($urandom_range(0, 127)); i_mnth = 4'($urandom);
        i_dmth = 5'($urandom); i_dwk = 3'($urandom); i_hour = 5'($urandom);
        i_min = 6'($urandom); i_sec = 6'($urandom);
      end
      if (m_xfer) access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else begin
        n = $urandom_range(0, 199);
        if (n == 0) access(1'b1, 1'b0);
        else if (n == 1) access(1'b0, ~PAT[m_ptr]);
        else access(1'b0, PAT[m_ptr]);
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
